// File: rtl/carrier_pll_loop.sv
`default_nettype none
// ============================================================================
//  Module      : carrier_pll_loop
//  Description : Carrier-phase tracking loop for the QAM-16 receiver.
//                One phase-error sample per symbol passes through a
//                power-of-two PI loop filter with a saturating integrator.
//                An NCO phase accumulator integrates the filter output and
//                produces the de-rotation phase for the rotation CORDIC.
//                Two gain sets are used: acquisition (ACQ) and tracking
//                (TRACK). A lock detector with hysteresis switches between
//                them. A hold input freezes adaptation while the NCO keeps
//                running at the held frequency.
//
//  Ports       : clk       in   rising-edge clock
//                rst       in   asynchronous reset, active-high
//                in_valid  in   one-cycle strobe qualifying phi_err
//                phi_err   in   signed phase error, full scale = +/-pi
//                hold      in   freeze integrator and lock counter
//                phi_out   out  NCO phase (top WIDTH bits of accumulator)
//                freq_out  out  integrator value (frequency estimate)
//                out_valid out  one-cycle strobe, outputs just updated
//                locked    out  1 while in TRACK
//                mode      out  0 = ACQ, 1 = TRACK
//
//  Revision    : 1.0  initial release
// ============================================================================
module carrier_pll_loop #(
    parameter int WIDTH        = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int KP_SHIFT_ACQ = 4,
    parameter int KI_SHIFT_ACQ = 8,
    parameter int KP_SHIFT_TRK = 6,
    parameter int KI_SHIFT_TRK = 11,
    parameter int LOCK_THRESH  = 1024,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     phi_err,
    input  logic                 hold,
    output logic [WIDTH-1:0]     phi_out,
    output logic [ACC_WIDTH-1:0] freq_out,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 mode
);

    // Number of fractional bits below the WIDTH-bit phase LSB.
    // ACC_WIDTH must be at least WIDTH.
    localparam int FRAC = ACC_WIDTH - WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]              c_LOCK_THRESH = (WIDTH+1)'(LOCK_THRESH);
    localparam logic [CNT_WIDTH-1:0]        c_LOCK_CNT    = CNT_WIDTH'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0]        c_UNLOCK_CNT  = CNT_WIDTH'(UNLOCK_COUNT);

    typedef enum logic [0:0] {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
    logic signed [ACC_WIDTH-1:0] phi_acc_q, phi_acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        out_valid_q;

    // ------------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------------
    logic signed [WIDTH-1:0]     w_err_s;
    logic signed [ACC_WIDTH-1:0] w_e_ext;
    logic signed [ACC_WIDTH-1:0] w_ki_term;
    logic signed [ACC_WIDTH-1:0] w_prop;
    logic signed [ACC_WIDTH-1:0] w_integ_new;
    logic signed [ACC_WIDTH-1:0] w_ctrl;
    logic [WIDTH:0]              w_err_x;
    logic [WIDTH:0]              w_abs;
    logic                        w_in_lock;
    logic [CNT_WIDTH-1:0]        w_cnt_inc;
    logic                        w_track;

    // Signed add clamped to the ACC_WIDTH range. One guard bit is enough
    // to detect overflow of a two-operand sum.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            sat_add = s[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
        end else begin
            sat_add = s[ACC_WIDTH-1:0];
        end
    endfunction

    assign w_err_s = phi_err;
    assign w_track = (state_q == ST_TRACK);

    // Place the WIDTH-bit error at the top of the accumulator word. The
    // result fills ACC_WIDTH bits exactly, so the sign bit lands in the MSB
    // and no separate sign extension is needed.
    generate
        if (FRAC > 0) begin : g_frac
            assign w_e_ext = {w_err_s, {FRAC{1'b0}}};
        end else begin : g_nofrac
            assign w_e_ext = w_err_s;
        end
    endgenerate

    // Gains come from the state held before this sample's transition.
    assign w_ki_term = w_track ? (w_e_ext >>> KI_SHIFT_TRK) : (w_e_ext >>> KI_SHIFT_ACQ);
    assign w_prop    = w_track ? (w_e_ext >>> KP_SHIFT_TRK) : (w_e_ext >>> KP_SHIFT_ACQ);

    assign w_integ_new = sat_add(integ_q, w_ki_term);
    assign w_ctrl      = sat_add(w_integ_new, w_prop);

    // |phi_err| in WIDTH+1 bits so the most negative input maps to
    // 2^(WIDTH-1) instead of wrapping back to itself.
    assign w_err_x   = {phi_err[WIDTH-1], phi_err};
    assign w_abs     = phi_err[WIDTH-1] ? (~w_err_x + (WIDTH+1)'(1)) : w_err_x;
    assign w_in_lock = (w_abs < c_LOCK_THRESH);

    assign w_cnt_inc = cnt_q + CNT_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        integ_d   = integ_q;
        phi_acc_d = phi_acc_q;
        cnt_d     = cnt_q;

        if (in_valid) begin
            if (hold) begin
                // Adaptation frozen: NCO free-runs at the held frequency.
                phi_acc_d = phi_acc_q + integ_q;
            end else begin
                integ_d   = w_integ_new;
                // Phase wraps modulo 2^ACC_WIDTH by design.
                phi_acc_d = phi_acc_q + w_ctrl;

                case (state_q)
                    ST_ACQ: begin
                        if (w_in_lock) begin
                            if (w_cnt_inc == c_LOCK_CNT) begin
                                state_d = ST_TRACK;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = w_cnt_inc;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    ST_TRACK: begin
                        if (!w_in_lock) begin
                            if (w_cnt_inc == c_UNLOCK_CNT) begin
                                state_d = ST_ACQ;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = w_cnt_inc;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d = ST_ACQ;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACQ;
            integ_q     <= '0;
            phi_acc_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            integ_q     <= integ_d;
            phi_acc_q   <= phi_acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= in_valid;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign phi_out   = phi_acc_q[ACC_WIDTH-1 -: WIDTH];
    assign freq_out  = integ_q;
    assign out_valid = out_valid_q;
    assign mode      = w_track;
    assign locked    = w_track;

endmodule
`default_nettype wire

// File: tb/tb_carrier_pll_loop.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carrier_pll_loop
//  Description : Self-checking bench for carrier_pll_loop. A sample-level
//                arithmetic model predicts every output each cycle; directed
//                sequences add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_carrier_pll_loop;

    localparam int  WIDTH     = 16;
    localparam int  ACC_WIDTH = 24;
    localparam int  FRAC      = ACC_WIDTH - WIDTH;
    localparam longint AMAX   = (longint'(1) << (ACC_WIDTH-1)) - 1;
    localparam longint AMIN   = -(longint'(1) << (ACC_WIDTH-1));
    localparam longint AMOD   = longint'(1) << ACC_WIDTH;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [WIDTH-1:0]     phi_err;
    logic                 hold;
    logic [WIDTH-1:0]     phi_out;
    logic [ACC_WIDTH-1:0] freq_out;
    logic                 out_valid;
    logic                 locked;
    logic                 mode;

    int n_checks = 0;
    int n_fail   = 0;

    carrier_pll_loop #(
        .WIDTH(16), .ACC_WIDTH(24),
        .KP_SHIFT_ACQ(4), .KI_SHIFT_ACQ(8),
        .KP_SHIFT_TRK(6), .KI_SHIFT_TRK(11),
        .LOCK_THRESH(1024), .LOCK_COUNT(64), .UNLOCK_COUNT(16),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .phi_err(phi_err),
        .hold(hold), .phi_out(phi_out), .freq_out(freq_out),
        .out_valid(out_valid), .locked(locked), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (sample level) ----------------
    function automatic longint fdiv(input longint a, input int sh);
        longint d, q;
        d = longint'(1) << sh;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint x);
        if (x > AMAX) return AMAX;
        if (x < AMIN) return AMIN;
        return x;
    endfunction

    longint m_integ, m_phi;
    int     m_cnt;
    bit     m_trk, m_valid;

    always @(posedge clk or posedge rst) begin
        longint e, ki_t, pr, ctrl, a;
        bit inl;
        if (rst) begin
            m_integ = 0; m_phi = 0; m_cnt = 0; m_trk = 0; m_valid = 0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                e    = longint'($signed(phi_err)) * (longint'(1) << FRAC);
                ki_t = fdiv(e, m_trk ? 11 : 8);
                pr   = fdiv(e, m_trk ? 6 : 4);
                a    = longint'($signed(phi_err));
                if (a < 0) a = -a;
                inl  = (a < 1024);
                if (hold) begin
                    ctrl = m_integ;
                end else begin
                    m_integ = sat(m_integ + ki_t);
                    ctrl    = sat(m_integ + pr);
                    if (!m_trk) begin
                        m_cnt = inl ? m_cnt + 1 : 0;
                        if (m_cnt == 64) begin m_trk = 1; m_cnt = 0; end
                    end else begin
                        m_cnt = inl ? 0 : m_cnt + 1;
                        if (m_cnt == 16) begin m_trk = 0; m_cnt = 0; end
                    end
                end
                m_phi = ((m_phi + ctrl) % AMOD + AMOD) % AMOD;
            end
        end
    end

    function automatic longint phase_top(input longint p);
        longint t;
        t = p / (longint'(1) << FRAC);
        if (t >= 32768) t = t - 65536;
        return t;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cyc_out_valid", longint'(out_valid), longint'(m_valid));
        chk("cyc_freq_out", longint'($signed(freq_out)), m_integ);
        chk("cyc_phi_out", longint'($signed(phi_out)), phase_top(m_phi));
        chk("cyc_mode", longint'(mode), longint'(m_trk));
        chk("cyc_locked", longint'(locked), longint'(m_trk));
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; phi_err = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic sample(input int e, input bit h);
        in_valid = 1'b1;
        phi_err  = WIDTH'(e);
        hold     = h;
        @(negedge clk);
        in_valid = 1'b0;
        hold     = 1'b0;
    endtask

    task automatic check_case1(input string tag);
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_freq"}, longint'($signed(freq_out)), 256);
        chk({tag, "_phi"}, longint'($signed(phi_out)), 17);
        chk({tag, "_mode"}, longint'(mode), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; phi_err = '0;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_freq", longint'($signed(freq_out)), 0);
        chk("rst_phi", longint'($signed(phi_out)), 0);
        chk("rst_locked", longint'(locked), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single sample
        sample(256, 0);
        check_case1("t1");
        @(negedge clk);
        chk("t1_pulse_one_cycle", longint'(out_valid), 0);
        chk("t1_hold_freq", longint'($signed(freq_out)), 256);

        // 2a: lock after exactly 64 in-lock samples
        do_reset();
        for (int i = 0; i < 63; i++) sample(0, 0);
        chk("t2_nolock63", longint'(locked), 0);
        sample(0, 0);
        chk("t2_lock64", longint'(locked), 1);
        chk("t2_mode64", longint'(mode), 1);

        // 2b: out-of-lock sample 40 restarts the count, lock at 104
        do_reset();
        for (int i = 1; i <= 103; i++) sample((i == 40) ? 1024 : 0, 0);
        chk("t2b_nolock103", longint'(locked), 0);
        sample(0, 0);
        chk("t2b_lock104", longint'(locked), 1);
        chk("t2b_freq", longint'($signed(freq_out)), 1024);

        // 3: unlock hysteresis in TRACK
        for (int i = 0; i < 15; i++) sample(2000, 0);
        sample(0, 0);
        chk("t3_still_locked", longint'(locked), 1);
        for (int i = 0; i < 15; i++) sample(2000, 0);
        chk("t3_locked15", longint'(locked), 1);
        chk("t3_freq15", longint'($signed(freq_out)), 8524);
        sample(2000, 0);
        chk("t3_unlock16", longint'(locked), 0);
        chk("t3_freq_cont", longint'($signed(freq_out)), 8774);

        // 4a: positive saturation
        do_reset();
        for (int i = 0; i < 256; i++) sample(32767, 0);
        chk("t4_freq256", longint'($signed(freq_out)), 8388352);
        sample(32767, 0);
        chk("t4_clamp_hi", longint'($signed(freq_out)), 8388607);
        sample(32767, 0);
        chk("t4_clamp_hi2", longint'($signed(freq_out)), 8388607);
        chk("t4_mode", longint'(mode), 0);

        // 4b: negative saturation; -32768 is never in lock
        do_reset();
        for (int i = 0; i < 256; i++) sample(-32768, 0);
        chk("t4_freq_neg256", longint'($signed(freq_out)), -8388608);
        for (int i = 0; i < 70; i++) sample(-32768, 0);
        chk("t4_clamp_lo", longint'($signed(freq_out)), -8388608);
        chk("t4_neg_nolock", longint'(locked), 0);

        // 5: hold
        do_reset();
        sample(256, 0);
        check_case1("t5_pre");
        sample(5000, 1);
        chk("t5_h1_freq", longint'($signed(freq_out)), 256);
        chk("t5_h1_phi", longint'($signed(phi_out)), 18);
        chk("t5_h1_valid", longint'(out_valid), 1);
        sample(5000, 1);
        chk("t5_h2_phi", longint'($signed(phi_out)), 19);
        sample(5000, 1);
        chk("t5_h3_phi", longint'($signed(phi_out)), 20);
        chk("t5_h3_freq", longint'($signed(freq_out)), 256);
        // Counter kept its value of 1 through the hold, so 63 more lock.
        for (int i = 0; i < 62; i++) sample(0, 0);
        chk("t5_nolock62", longint'(locked), 0);
        sample(0, 0);
        chk("t5_lock63", longint'(locked), 1);

        // 6: asynchronous reset mid-burst
        do_reset();
        sample(256, 0);
        sample(1000, 0);
        in_valid = 1'b1;
        phi_err  = WIDTH'(777);
        @(posedge clk);
        #1;
        chk("t6_pre_valid", longint'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", longint'(out_valid), 0);
        chk("t6_async_freq", longint'($signed(freq_out)), 0);
        chk("t6_async_phi", longint'($signed(phi_out)), 0);
        chk("t6_async_mode", longint'(mode), 0);
        @(posedge clk);
        #1;
        chk("t6_no_pulse", longint'(out_valid), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sample(256, 0);
        check_case1("t6_repro");
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
